pb_debounce_multi: RTL

- Parametrised, multi-channel successor to the single pushbutton debouncer.
- Each channel has:
  - a synchroniser on the raw pad input;
  - a stability counter that must see STABLE_CYCLES consecutive agreeing samples before the debounced level changes;
  - one-cycle press and release pulses.
- Sits between the board pushbuttons/switches and the control FSMs, which consume either levels or edge pulses.

---
 rtl/pb_debounce_pkg.sv | 21 ++
 rtl/pb_debounce_ch.sv | 87 ++++++++
 rtl/pb_debounce_multi.sv | 66 ++++++
 3 files changed

// File: rtl/pb_debounce_pkg.sv
// pb_debounce_pkg
//   Constants and helpers shared by the multi-channel pushbutton debouncer.
//   DEF_SYNC_STAGES   : default synchroniser depth per channel.
//   DEF_STABLE_CYCLES : default number of agreeing sample ticks before a flip.
//   min_cnt_w()       : narrowest counter width able to hold a STABLE_CYCLES value.
package pb_debounce_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 500000;

  // Smallest w such that 2^w - 1 >= stable_cycles (never below 1 bit).
  function automatic int min_cnt_w(input int stable_cycles);
    int w;
    w = 1;
    while (((longint'(1) << w) - longint'(1)) < longint'(stable_cycles)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// pb_debounce_ch
//   One debounce channel: synchroniser, stability counter, debounced level
//   and registered one-cycle press/release pulses.
//   clk           : system clock, rising edge
//   clear         : asynchronous active-high reset of all channel state
//   sample_en     : counter advances only on cycles where this is high
//   inp_pb        : raw asynchronous pad input
//   out_pb        : debounced level (registered)
//   press_pulse   : one-cycle pulse when out_pb goes 0->1 (registered)
//   release_pulse : one-cycle pulse when out_pb goes 1->0 (registered)
//   flip_next     : combinational, high when the next edge will flip out_pb
module pb_debounce_ch
  import pb_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = 20,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic clear,
  input  logic sample_en,
  input  logic inp_pb,
  output logic out_pb,
  output logic press_pulse,
  output logic release_pulse,
  output logic flip_next
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   sync_s;
  logic                   flip_s;

  assign sync_s    = sync_r[SYNC_STAGES-1];
  assign flip_next = flip_s;

  // Synchroniser shift register; runs every clock independent of sample_en.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], inp_pb};
    end
  end

  // A flip happens on a sampled disagreement once the run has reached its last count.
  always_comb begin
    flip_s = 1'b0;
    if (sample_en && (sync_s != out_pb) && (cnt_r == CNT_LAST)) begin
      flip_s = 1'b1;
    end else begin
      flip_s = 1'b0;
    end
  end

  // Stability counter, debounced level and edge pulses.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_r         <= {CNT_W{1'b0}};
      out_pb        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless a flip re-asserts them below.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sample_en) begin
        if (sync_s == out_pb) begin
          // Agreement breaks any disagreement run, so short glitches die here.
          cnt_r <= {CNT_W{1'b0}};
        end else if (flip_s) begin
          cnt_r         <= {CNT_W{1'b0}};
          out_pb        <= sync_s;
          press_pulse   <= sync_s;
          release_pulse <= ~sync_s;
        end else begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/pb_debounce_multi.sv
// pb_debounce_multi
//   N_CH independent pushbutton debouncers with a shared sampling tick.
//   clk           : system clock, rising edge
//   clear         : asynchronous active-high reset of all state
//   sample_en     : sampling tick; tie high to count every clock
//   inp_pb        : raw asynchronous button inputs, one bit per channel
//   out_pb        : debounced levels
//   press_pulse   : one-cycle pulses on 0->1 of out_pb
//   release_pulse : one-cycle pulses on 1->0 of out_pb
//   any_event     : OR of all pulses, registered in the same cycle as them
module pb_debounce_multi
  import pb_debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = 20,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            sample_en,
  input  logic [N_CH-1:0] inp_pb,
  output logic [N_CH-1:0] out_pb,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic            any_event
);

  // Reject illegal parameterisations at elaboration time.
  if ((STABLE_CYCLES < 1) ||
      (longint'(STABLE_CYCLES) > ((longint'(1) << CNT_W) - longint'(1)))) begin : g_bad_stable
    $error("pb_debounce_multi: STABLE_CYCLES out of range for CNT_W");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pb_debounce_multi: SYNC_STAGES must be at least 2");
  end

  logic [N_CH-1:0] flip_s;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pb_debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .CNT_W        (CNT_W),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .clear        (clear),
      .sample_en    (sample_en),
      .inp_pb       (inp_pb[i]),
      .out_pb       (out_pb[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .flip_next    (flip_s[i])
    );
  end

  // any_event is built from the channels' next-flip terms so it lands in the same cycle as the pulses.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      any_event <= 1'b0;
    end else begin
      any_event <= |flip_s;
    end
  end

endmodule
